// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link (generator and checker sides):
// FSM state encoding, line levels and a counter-width helper.
package parity_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // One spare bit so the bit counter never wraps inside a frame.
  function automatic int cnt_width(input int data_bits);
    return $clog2(data_bits) + 1;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// Running XOR register with clear and enable; the same function the transmit-side
// parity generator uses, so both ends of the link agree on the accumulated parity.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  logic acc_q, acc_d;

  // NOTE: every always_comb variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive-side deframer: start(0), DATA_BITS data LSB first, parity, stop(1).
// Optional saturating error counter on port err_count when PARITY_ERR_COUNT_EN is defined.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x,
  input  logic                 bit_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam int CNT_W = cnt_width(DATA_BITS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 acc_clr, acc_en, acc;
  logic                 last_bit;

  assign last_bit = (cnt_q == CNT_W'(DATA_BITS - 1));

  parity_accum u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .d     (x),
    .acc   (acc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the FSM only moves on bit strobes.
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        IDLE:    if (x == START_BIT) state_d = DATA;
        DATA:    if (last_bit) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: bit counter, shift register, parity verdict and the delivered word/flags.
  always_comb begin
    cnt_d        = cnt_q;
    word_d       = word_q;
    perr_d       = perr_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (x == START_BIT) begin
            cnt_d   = '0;
            acc_clr = 1'b1;
          end
        end
        DATA: begin
          // Shift right so the first (LSB) bit ends up in bit 0 after DATA_BITS shifts.
          word_d = (word_q >> 1) | (DATA_BITS'(x) << (DATA_BITS - 1));
          acc_en = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        PARITY: begin
          perr_d = acc ^ x ^ ODD_PARITY;
        end
        STOP: begin
          if (x == LINE_IDLE) begin
            data_d       = word_q;
            data_valid_d = 1'b1;
            parity_err_d = perr_q;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      word_q       <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q != IDLE);
    data       = data_q;
    data_valid = data_valid_q;
    parity_err = parity_err_q;
    frame_err  = frame_err_q;
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counts alongside the pulse being registered so err_count moves with the flag.
  always_comb begin
    err_count_d = err_count_q;
    if ((parity_err_d || frame_err_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even-parity DUT plus an ODD_PARITY=1 twin
// on the same line; err_count checks are compiled in with PARITY_ERR_COUNT_EN.
module tb_serial_parity_checker;

  logic       clk;
  logic       rst_n;
  logic       x;
  logic       bit_en;
  logic [7:0] data, data_odd;
  logic       data_valid, parity_err, frame_err, busy;
  logic       data_valid_odd, parity_err_odd, frame_err_odd, busy_odd;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] err_count, err_count_odd;
`endif

  int errors = 0;
  int checks = 0;

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .bit_en     (bit_en),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef PARITY_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .bit_en     (bit_en),
    .data       (data_odd),
    .data_valid (data_valid_odd),
    .parity_err (parity_err_odd),
    .frame_err  (frame_err_odd),
    .busy       (busy_odd)
`ifdef PARITY_ERR_COUNT_EN
    ,
    .err_count  (err_count_odd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic [7:0] word;
    logic       p;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_perr_odd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bit strobe, preceded by gap-1 cycles with bit_en low; returns #1 after the sampling edge.
  task automatic send_bit(input logic b, input int gap);
    x      = b;
    bit_en = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    x      = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic p, input logic stop, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(w[i], gap);
    send_bit(p, gap);
    send_bit(stop, gap);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             gap word   p     stop  data   vld   perr  ferr  perr_odd
    vecs[0] = '{1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1, 8'h5A, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3, 8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{2, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n  = 1'b0;
    x      = 1'b1;
    bit_en = 1'b0;
    repeat (3) idle_cycle();
    check("reset data",       32'(data),       32'h00);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    check("reset frame_err",  32'(frame_err),  32'h0);
    check("reset busy",       32'(busy),       32'h0);
    rst_n = 1'b1;

    // Idle line with strobes must not start a frame.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
    check("idle busy",  32'(busy), 32'h0);
    check("idle flags", 32'({data_valid, parity_err, frame_err}), 32'h0);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].word, vecs[v].p, vecs[v].stop, vecs[v].gap);
      check($sformatf("vec%0d data", v),       32'(data),       32'(vecs[v].exp_data));
      check($sformatf("vec%0d data_valid", v), 32'(data_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
      check($sformatf("vec%0d frame_err", v),  32'(frame_err),  32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d busy", v),       32'(busy),       32'h0);
      check($sformatf("vec%0d odd parity_err", v), 32'(parity_err_odd), 32'(vecs[v].exp_perr_odd));
      idle_cycle();
      check($sformatf("vec%0d pulses clear", v), 32'({data_valid, parity_err, frame_err}), 32'h0);
      check($sformatf("vec%0d data held", v),    32'(data), 32'(vecs[v].exp_data));
    end

    // Back-to-back frames: next start bit on the very next strobe after stop.
    send_frame(8'h12, 1'b0, 1'b1, 1);
    check("b2b first data",  32'(data), 32'h12);
    check("b2b first flags", 32'({data_valid, parity_err, frame_err}), 32'b100);
    send_frame(8'h34, 1'b1, 1'b1, 1);
    check("b2b second data",  32'(data), 32'h34);
    check("b2b second flags", 32'({data_valid, parity_err, frame_err}), 32'b100);
    idle_cycle();

    // Reset mid-frame discards the partial frame.
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    check("midframe busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    check("post-reset busy",  32'(busy), 32'h0);
    check("post-reset data",  32'(data), 32'h00);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1);
      check("post-reset no pulse", 32'({data_valid, parity_err, frame_err}), 32'h0);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    check("after reset data",  32'(data), 32'h3C);
    check("after reset flags", 32'({data_valid, parity_err, frame_err}), 32'b100);
    idle_cycle();

`ifdef PARITY_ERR_COUNT_EN
    check("err_count start", 32'(err_count), 32'd0);
    send_frame(8'h00, 1'b1, 1'b1, 1);
    send_frame(8'h00, 1'b1, 1'b1, 1);
    send_frame(8'h11, 1'b0, 1'b0, 1);
    idle_cycle();
    check("err_count three", 32'(err_count), 32'd3);
    for (int i = 0; i < 297; i++) send_frame(8'h00, 1'b1, 1'b1, 1);
    idle_cycle();
    check("err_count saturated", 32'(err_count), 32'd255);
    send_frame(8'h00, 1'b1, 1'b1, 1);
    idle_cycle();
    check("err_count stays 255", 32'(err_count), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
